// File: rtl/instr_sequencer.sv
// Issue-side sequencer: streams a loaded program into the processor one word per
// cycle and captures the returning results, tagged with their program index.
module instr_sequencer #(
  parameter int         DEPTH = 16,
  parameter int         AW    = 4,
  parameter int         LAT   = 3,
  parameter logic [7:0] NOP   = 8'h07
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          hold,
  output logic [7:0]    instr_out,
  output logic          instr_valid,
  input  logic [7:0]    result_in,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [AW-1:0] res_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_t        state_q;
  logic [AW:0]   pc_q, len_q, cnt_q;
  logic [AW:0]   len_sat_d, cnt_d, pc_inc_d;
  logic [7:0]    instr_q;
  logic          ivalid_q;
  logic [AW-1:0] iidx_q;
  logic          vpipe_q [LAT];
  logic [AW-1:0] ipipe_q [LAT];
  logic          res_valid_q, busy_q, done_q;
  logic [7:0]    res_data_q;
  logic [AW-1:0] res_idx_q;
  logic          cap_d;
  logic [7:0]    mem_q [DEPTH];

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == IDLE) mem_q[prog_addr] <= prog_data;
  end

  always_comb begin
    len_sat_d = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    cap_d     = vpipe_q[LAT-1];
    cnt_d     = cap_d ? cnt_q + ONE : cnt_q;
    pc_inc_d  = pc_q + ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      instr_q     <= NOP;
      ivalid_q    <= 1'b0;
      iidx_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        vpipe_q[i] <= 1'b0;
        ipipe_q[i] <= '0;
      end
    end else begin
      vpipe_q[0] <= ivalid_q;
      ipipe_q[0] <= iidx_q;
      for (int i = 1; i < LAT; i++) begin
        vpipe_q[i] <= vpipe_q[i-1];
        ipipe_q[i] <= ipipe_q[i-1];
      end
      res_valid_q <= cap_d;
      if (cap_d) begin
        res_data_q <= result_in;
        res_idx_q  <= ipipe_q[LAT-1];
      end
      cnt_q  <= cnt_d;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          instr_q  <= NOP;
          ivalid_q <= 1'b0;
          if (start) begin
            len_q <= len_sat_d;
            pc_q  <= '0;
            cnt_q <= '0;
            if (len_sat_d != '0) begin
              state_q <= ISSUE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!hold) begin
            instr_q  <= mem_q[pc_q[AW-1:0]];
            ivalid_q <= 1'b1;
            iidx_q   <= pc_q[AW-1:0];
            pc_q     <= pc_inc_d;
            if (pc_inc_d == len_q) state_q <= DRAIN;
          end else begin
            instr_q  <= NOP;
            ivalid_q <= 1'b0;
          end
        end
        DRAIN: begin
          instr_q  <= NOP;
          ivalid_q <= 1'b0;
          // Count includes this edge's capture so done lines up with the last result.
          if (cnt_d == len_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = ivalid_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_idx     = res_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a 3-cycle processor model feeds results
// back, a monitor pops expected {idx,data} pairs whenever res_valid pulses.
module tb_instr_sequencer;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic       start;
  logic       hold;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic [7:0] result_in;
  logic       res_valid;
  logic [7:0] res_data;
  logic [3:0] res_idx;
  logic       busy;
  logic       done;

  int passCount = 0;
  int checkCount = 0;
  logic [11:0] expQ[$];

  logic [63:0] validMask;
  int doneCount, doneCycle, resCount;
  bit busySeen;

  logic [7:0] pd0 = 8'h07, pd1 = 8'h07, pd2 = 8'h07;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .hold(hold),
    .instr_out(instr_out), .instr_valid(instr_valid), .result_in(result_in),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor model: op 0 passes the high nibble, op 1 decrements it, op 7 yields 0.
  function automatic logic [7:0] procModel(input logic [7:0] ins);
    case (ins[2:0])
      3'd0:    procModel = {4'h0, ins[7:4]};
      3'd1:    procModel = {4'h0, ins[7:4] - 4'd1};
      3'd7:    procModel = 8'h00;
      default: procModel = {4'h0, ins[7:4]};
    endcase
  endfunction

  always @(posedge clk) begin
    pd0 <= instr_out;
    pd1 <= pd0;
    pd2 <= pd1;
  end
  assign result_in = procModel(pd2);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic expectResult(input logic [3:0] idx, input logic [7:0] data);
    expQ.push_back({idx, data});
  endtask

  // Monitor: every res_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_res", {20'h0, res_idx, res_data}, 32'hFFFFFFFF);
      end else begin
        logic [11:0] e;
        e = expQ.pop_front();
        checkOutput("res_idx_data", {20'h0, res_idx, res_data}, {20'h0, e});
      end
    end
  end

  task automatic loadWord(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Starts a run and records per-cycle behaviour; cycle 1 is the first after the start edge.
  task automatic applyStimulus(input logic [4:0] len, input int holdCycle, input int noiseCycle,
                               input bit weWithStart, input logic [7:0] weWord);
    @(negedge clk);
    start = 1'b1; prog_len = len;
    if (weWithStart) begin
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = weWord;
    end
    validMask = '0; doneCount = 0; doneCycle = 0; resCount = 0; busySeen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0; hold = 1'b0;
      if (c == holdCycle) hold = 1'b1;
      if (c == noiseCycle) begin
        start = 1'b1; prog_len = 5'd2;
        prog_we = 1'b1; prog_addr = 4'd3; prog_data = 8'hF0;
      end
      if (instr_valid) validMask[c] = 1'b1;
      if (busy) busySeen = 1'b1;
      if (res_valid) resCount++;
      if (done) begin doneCount++; doneCycle = c; end
      if (doneCount > 0 && c > doneCycle + 3) break;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_instr_out"}, 32'(instr_out), 32'h07);
    checkOutput({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'h0);
    checkOutput({tag, "_res_data"}, 32'(res_data), 32'h0);
    checkOutput({tag, "_res_idx"}, 32'(res_idx), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc;
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    prog_len = '0; start = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("por");
    reset = 1'b0;

    loadWord(4'd0, 8'h50);
    loadWord(4'd1, 8'h31);
    loadWord(4'd2, 8'h94);

    // Reset in the middle of ISSUE aborts immediately with no done pulse.
    @(negedge clk); start = 1'b1; prog_len = 5'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checkOutput("midrun_valid_before_reset", 32'(instr_valid), 32'h1);
    #2 reset = 1'b1;
    #1 checkResetOutputs("midrun");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    checkOutput("midrun_no_done_busy", 32'(dc), 32'h0);

    // Basic 3-instruction run; program survived reset.
    expectResult(4'd0, 8'h05); expectResult(4'd1, 8'h02); expectResult(4'd2, 8'h09);
    applyStimulus(5'd3, 0, 0, 1'b0, 8'h00);
    checkOutput("run3_valid_mask", validMask[31:0], 32'h0000001C);
    checkOutput("run3_done_count", 32'(doneCount), 32'd1);
    checkOutput("run3_done_cycle", 32'(doneCycle), 32'd8);
    checkOutput("run3_res_count", 32'(resCount), 32'd3);

    // Hold on the second issue cycle leaves one filler gap.
    expectResult(4'd0, 8'h05); expectResult(4'd1, 8'h02); expectResult(4'd2, 8'h09);
    applyStimulus(5'd3, 2, 0, 1'b0, 8'h00);
    checkOutput("hold_valid_mask", validMask[31:0], 32'h00000034);
    checkOutput("hold_done_cycle", 32'(doneCycle), 32'd9);
    checkOutput("hold_res_count", 32'(resCount), 32'd3);

    // Zero-length run.
    applyStimulus(5'd0, 0, 0, 1'b0, 8'h00);
    checkOutput("len0_done_cycle", 32'(doneCycle), 32'd1);
    checkOutput("len0_done_count", 32'(doneCount), 32'd1);
    checkOutput("len0_busy_seen", 32'(busySeen), 32'h0);
    checkOutput("len0_res_count", 32'(resCount), 32'd0);

    // Full-depth run with start/prog_we noise mid-run.
    for (int i = 0; i < 16; i++) loadWord(4'(i), {4'(i), 4'h0});
    for (int i = 0; i < 16; i++) expectResult(4'(i), 8'(i));
    applyStimulus(5'd16, 0, 5, 1'b0, 8'h00);
    checkOutput("full_valid_mask", validMask[31:0], 32'h0003FFFC);
    checkOutput("full_done_cycle", 32'(doneCycle), 32'd21);
    checkOutput("full_done_count", 32'(doneCount), 32'd1);
    checkOutput("full_res_count", 32'(resCount), 32'd16);

    // Re-run the first four words: mem[3] must be untouched by the mid-run write.
    for (int i = 0; i < 4; i++) expectResult(4'(i), 8'(i));
    applyStimulus(5'd4, 0, 0, 1'b0, 8'h00);
    checkOutput("memkeep_res_count", 32'(resCount), 32'd4);

    // Oversized length saturates to the full depth.
    for (int i = 0; i < 16; i++) expectResult(4'(i), 8'(i));
    applyStimulus(5'd25, 0, 0, 1'b0, 8'h00);
    checkOutput("sat_res_count", 32'(resCount), 32'd16);
    checkOutput("sat_done_cycle", 32'(doneCycle), 32'd21);

    // Write and start in the same cycle: the new word is issued first.
    expectResult(4'd0, 8'h08);
    applyStimulus(5'd1, 0, 0, 1'b1, 8'h80);
    checkOutput("wrstart_valid_mask", validMask[31:0], 32'h00000004);
    checkOutput("wrstart_done_cycle", 32'(doneCycle), 32'd6);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
